// File: rtl/key_motion_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// key_motion_ctrl_pkg
// Shared constants and types for the keyboard motion/zoom front end:
//   - HID usage codes for the WASD keys (and the arrow keys when KEY_ARROW_EN
//     is defined)
//   - one-hot motion codes consumed by the ball stage
//   - the zoom repeat FSM state enum
//   - cnt_width(): counter width that holds the largest of three limits
// Optional feature macro: KEY_ARROW_EN (adds arrow-key usages)
// -----------------------------------------------------------------------------
package key_motion_ctrl_pkg;

   localparam int HID_W = 8;
   localparam int KC_W  = 6;

   localparam logic [HID_W-1:0] HID_A = 8'h04;
   localparam logic [HID_W-1:0] HID_D = 8'h07;
   localparam logic [HID_W-1:0] HID_W_KEY = 8'h1A;
   localparam logic [HID_W-1:0] HID_S = 8'h16;
`ifdef KEY_ARROW_EN
   localparam logic [HID_W-1:0] HID_LEFT  = 8'h50;
   localparam logic [HID_W-1:0] HID_RIGHT = 8'h4F;
   localparam logic [HID_W-1:0] HID_UP    = 8'h52;
   localparam logic [HID_W-1:0] HID_DOWN  = 8'h51;
`endif

   localparam logic [KC_W-1:0] KC_NONE  = 6'b000000;
   localparam logic [KC_W-1:0] KC_LEFT  = 6'b100000;
   localparam logic [KC_W-1:0] KC_RIGHT = 6'b010000;
   localparam logic [KC_W-1:0] KC_UP    = 6'b001000;
   localparam logic [KC_W-1:0] KC_DOWN  = 6'b000100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRESS  = 2'd1,
      DELAY  = 2'd2,
      REPEAT = 2'd3
   } zoom_state_t;

   // Width of an unsigned counter able to hold max(a, b, c) without wrapping.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_motion_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_motion_ctrl_if
// Bundle between the USB host side and the ball/zoom stage.
//   hid_keycode  raw HID usage (asynchronous to frame_clk), 8'h00 = no key
//   keycode      one-hot motion code (A/D/W/S)
//   Zoom_In      one-cycle zoom-in pulse
//   Zoom_Out     one-cycle zoom-out pulse
//   key_active   accepted code is a mapped key
// Modports: master = keycode source / result consumer, slave = controller.
// -----------------------------------------------------------------------------
interface key_motion_ctrl_if;
   import key_motion_ctrl_pkg::*;

   logic [HID_W-1:0] hid_keycode;
   logic [KC_W-1:0]  keycode;
   logic             Zoom_In;
   logic             Zoom_Out;
   logic             key_active;

   modport master (output hid_keycode, input keycode, Zoom_In, Zoom_Out, key_active);
   modport slave  (input hid_keycode, output keycode, Zoom_In, Zoom_Out, key_active);
endinterface

// File: rtl/key_motion_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser followed by a candidate/counter debouncer. A code is
// accepted into stable_code once DEBOUNCE consecutive synced samples agree.
// Ports:
//   frame_clk    clock
//   Reset_n      asynchronous active-low reset
//   hid_keycode  raw asynchronous HID usage
//   stable_code  debounced, accepted usage
// -----------------------------------------------------------------------------
module key_debounce
   import key_motion_ctrl_pkg::*;
#(
   parameter int DEBOUNCE = 2,
   parameter int CNT_W    = 2
) (
   input  logic             frame_clk,
   input  logic             Reset_n,
   input  logic [HID_W-1:0] hid_keycode,
   output logic [HID_W-1:0] stable_code
);

   localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [HID_W-1:0] s1_r;
   logic [HID_W-1:0] s2_r;
   logic [HID_W-1:0] cand_r;
   logic [HID_W-1:0] stable_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   // Agreement counter: restart on a new candidate, saturate at DEBOUNCE
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (s2_r != cand_r) begin
         cnt_nxt_s = CNT_ONE;
      end else if (cnt_r >= DB_MAX) begin
         cnt_nxt_s = DB_MAX;
      end else begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end
   end

   // Synchroniser, candidate tracking and acceptance of the stable code
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_r     <= {HID_W{1'b0}};
         s2_r     <= {HID_W{1'b0}};
         cand_r   <= {HID_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         stable_r <= {HID_W{1'b0}};
      end else begin
         s1_r   <= hid_keycode;
         s2_r   <= s1_r;
         cand_r <= s2_r;
         cnt_r  <= cnt_nxt_s;
         // s2 is the candidate on this edge either way, so accept it directly
         if (cnt_nxt_s == DB_MAX) begin
            stable_r <= s2_r;
         end else begin
            stable_r <= stable_r;
         end
      end
   end

   assign stable_code = stable_r;

endmodule

// File: rtl/key_motion_ctrl.sv
// -----------------------------------------------------------------------------
// key_motion_ctrl
// Turns the raw HID keycode into a one-hot motion level plus one-cycle
// Zoom_In / Zoom_Out pulses, with auto-repeat while a zoom key is held.
// Ports:
//   frame_clk  sole clock
//   Reset_n    asynchronous active-low reset
//   bus        key_motion_ctrl_if.slave (hid_keycode in; keycode, Zoom_In,
//              Zoom_Out, key_active out, all registered)
// Optional feature macro: KEY_ARROW_EN maps the arrow keys onto A/D/W/S.
// -----------------------------------------------------------------------------
module key_motion_ctrl
   import key_motion_ctrl_pkg::*;
#(
   parameter int               DEBOUNCE      = 2,
   parameter int               REPEAT_DELAY  = 30,
   parameter int               REPEAT_RATE   = 6,
   parameter logic [HID_W-1:0] ZOOM_IN_CODE  = 8'h2E,
   parameter logic [HID_W-1:0] ZOOM_OUT_CODE = 8'h2D
) (
   input logic              frame_clk,
   input logic              Reset_n,
   key_motion_ctrl_if.slave bus
);

   localparam int CNT_W = cnt_width(DEBOUNCE, REPEAT_DELAY, REPEAT_RATE);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

   logic [HID_W-1:0] stable_code_s;
   logic [KC_W-1:0]  dir_s;
   logic             dir_active_s;
   logic             is_in_s;
   logic             is_out_s;
   logic             is_zoom_s;

   zoom_state_t      state_r;
   zoom_state_t      state_nxt_s;
   logic [CNT_W-1:0] rcnt_r;
   logic [CNT_W-1:0] rcnt_nxt_s;
   logic             zout_r;       // held zoom key is zoom-out
   logic             zout_nxt_s;
   logic             pulse_s;

   logic [KC_W-1:0]  keycode_r;
   logic             key_active_r;
   logic             zoom_in_r;
   logic             zoom_out_r;

   key_debounce #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
   ) u_debounce (
      .frame_clk   (frame_clk),
      .Reset_n     (Reset_n),
      .hid_keycode (bus.hid_keycode),
      .stable_code (stable_code_s)
   );

   // Direction decode of the accepted code
   always_comb begin
      dir_s        = KC_NONE;
      dir_active_s = 1'b0;
      case (stable_code_s)
         HID_A:     begin dir_s = KC_LEFT;  dir_active_s = 1'b1; end
         HID_D:     begin dir_s = KC_RIGHT; dir_active_s = 1'b1; end
         HID_W_KEY: begin dir_s = KC_UP;    dir_active_s = 1'b1; end
         HID_S:     begin dir_s = KC_DOWN;  dir_active_s = 1'b1; end
`ifdef KEY_ARROW_EN
         HID_LEFT:  begin dir_s = KC_LEFT;  dir_active_s = 1'b1; end
         HID_RIGHT: begin dir_s = KC_RIGHT; dir_active_s = 1'b1; end
         HID_UP:    begin dir_s = KC_UP;    dir_active_s = 1'b1; end
         HID_DOWN:  begin dir_s = KC_DOWN;  dir_active_s = 1'b1; end
`endif
         default:   begin dir_s = KC_NONE;  dir_active_s = 1'b0; end
      endcase
   end

   assign is_in_s   = (stable_code_s == ZOOM_IN_CODE);
   assign is_out_s  = (stable_code_s == ZOOM_OUT_CODE);
   assign is_zoom_s = is_in_s | is_out_s;

   // Zoom repeat FSM: next state, counter reload and pulse request
   always_comb begin
      state_nxt_s = state_r;
      rcnt_nxt_s  = rcnt_r;
      zout_nxt_s  = zout_r;
      pulse_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (is_zoom_s) begin
               state_nxt_s = PRESS;
               rcnt_nxt_s  = DELAY_LOAD;
               zout_nxt_s  = is_out_s;
               pulse_s     = 1'b1;
            end else begin
               rcnt_nxt_s  = CNT_ZERO;
            end
         end
         PRESS, DELAY, REPEAT: begin
            if (!is_zoom_s) begin
               state_nxt_s = IDLE;
               rcnt_nxt_s  = CNT_ZERO;
            end else if (is_out_s != zout_r) begin
               // The other zoom key took over: treat it as a fresh press
               state_nxt_s = PRESS;
               rcnt_nxt_s  = DELAY_LOAD;
               zout_nxt_s  = is_out_s;
               pulse_s     = 1'b1;
            end else if (rcnt_r == CNT_ZERO) begin
               state_nxt_s = REPEAT;
               rcnt_nxt_s  = RATE_LOAD;
               pulse_s     = 1'b1;
            end else begin
               state_nxt_s = (state_r == PRESS) ? DELAY : state_r;
               rcnt_nxt_s  = rcnt_r - CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            rcnt_nxt_s  = CNT_ZERO;
         end
      endcase
   end

   // FSM state and registered outputs
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r      <= IDLE;
         rcnt_r       <= CNT_ZERO;
         zout_r       <= 1'b0;
         keycode_r    <= KC_NONE;
         key_active_r <= 1'b0;
         zoom_in_r    <= 1'b0;
         zoom_out_r   <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         rcnt_r       <= rcnt_nxt_s;
         zout_r       <= zout_nxt_s;
         keycode_r    <= dir_s;
         key_active_r <= dir_active_s | is_zoom_s;
         zoom_in_r    <= pulse_s & ~zout_nxt_s;
         zoom_out_r   <= pulse_s & zout_nxt_s;
      end
   end

   assign bus.keycode    = keycode_r;
   assign bus.key_active = key_active_r;
   assign bus.Zoom_In    = zoom_in_r;
   assign bus.Zoom_Out   = zoom_out_r;

endmodule

// File: tb/tb_key_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_motion_ctrl
// Directed bench for key_motion_ctrl. Each step drives hid_keycode on a
// falling edge, pushes the expected output for every following rising edge
// into a scoreboard queue, then pops and compares one entry per edge.
// -----------------------------------------------------------------------------
module tb_key_motion_ctrl;

   localparam int LAT = 5;    // input change to registered output, in edges
   localparam int RD  = 30;
   localparam int RR  = 6;

   typedef struct packed {
      logic [5:0] kc;
      logic       act;
      logic       zi;
      logic       zo;
      logic       chk_act;
   } exp_t;

   logic frame_clk = 1'b0;
   logic Reset_n   = 1'b0;
   exp_t exp_q[$];
   int   n_checks  = 0;
   int   n_err     = 0;

   key_motion_ctrl_if bus();

   key_motion_ctrl u_dut (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .bus       (bus)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Level outputs change from (kc0,a0) to (kc1,a1) on edge LAT; no pulses.
   task automatic push_level(input int n, input logic [5:0] kc0, input logic a0,
                             input logic [5:0] kc1, input logic a1, input logic chk);
      exp_t e;
      for (int k = 1; k <= n; k++) begin
         e.kc      = (k < LAT) ? kc0 : kc1;
         e.act     = (k < LAT) ? a0 : a1;
         e.zi      = 1'b0;
         e.zo      = 1'b0;
         e.chk_act = chk;
         exp_q.push_back(e);
      end
   endtask

   // Zoom key held from edge 1: first pulse at LAT, then LAT+RD, then every RR.
   task automatic push_zoom(input int n, input logic is_out);
      exp_t e;
      logic p;
      for (int k = 1; k <= n; k++) begin
         p = (k == LAT) || ((k >= LAT + RD) && (((k - LAT - RD) % RR) == 0));
         e.kc      = 6'b000000;
         e.act     = 1'b0;
         e.zi      = p & ~is_out;
         e.zo      = p & is_out;
         e.chk_act = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic run(input int n, input string tag);
      exp_t e;
      for (int k = 1; k <= n; k++) begin
         @(posedge frame_clk);
         @(negedge frame_clk);
         if (exp_q.size() == 0) begin
            check($sformatf("%s.sb_empty@%0d", tag, k), 8'h01, 8'h00);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("%s.kc@%0d", tag, k), {2'b00, bus.keycode}, {2'b00, e.kc});
            check($sformatf("%s.zoom@%0d", tag, k), {6'b000000, bus.Zoom_In, bus.Zoom_Out},
                  {6'b000000, e.zi, e.zo});
            if (e.chk_act) begin
               check($sformatf("%s.act@%0d", tag, k), {7'b0000000, bus.key_active},
                     {7'b0000000, e.act});
            end
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".kc"}, {2'b00, bus.keycode}, 8'h00);
      check({tag, ".zi"}, {7'b0000000, bus.Zoom_In}, 8'h00);
      check({tag, ".zo"}, {7'b0000000, bus.Zoom_Out}, 8'h00);
      check({tag, ".act"}, {7'b0000000, bus.key_active}, 8'h00);
   endtask

   initial begin
      logic [7:0] codes[3];
      logic [5:0] kcs[3];
      codes[0] = 8'h04; kcs[0] = 6'b100000;
      codes[1] = 8'h1A; kcs[1] = 6'b001000;
      codes[2] = 8'h16; kcs[2] = 6'b000100;

      // reset state
      bus.hid_keycode = 8'h00;
      repeat (3) @(negedge frame_clk);
      check_all_zero("reset");
      Reset_n = 1'b1;
      push_level(8, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b1);
      run(8, "idle");

      // D key press and release
      bus.hid_keycode = 8'h07;
      push_level(10, 6'b000000, 1'b0, 6'b010000, 1'b1, 1'b1);
      run(10, "d_press");
      bus.hid_keycode = 8'h00;
      push_level(8, 6'b010000, 1'b1, 6'b000000, 1'b0, 1'b1);
      run(8, "d_release");

      // remaining direction keys
      for (int i = 0; i < 3; i++) begin
         bus.hid_keycode = codes[i];
         push_level(6, 6'b000000, 1'b0, kcs[i], 1'b1, 1'b1);
         run(6, $sformatf("dir%0d_press", i));
         bus.hid_keycode = 8'h00;
         push_level(6, kcs[i], 1'b1, 6'b000000, 1'b0, 1'b1);
         run(6, $sformatf("dir%0d_release", i));
      end

      // single-sample glitch is rejected
      bus.hid_keycode = 8'h1A;
      push_level(1, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b1);
      run(1, "glitch_on");
      bus.hid_keycode = 8'h00;
      push_level(8, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b1);
      run(8, "glitch_off");

      // unmapped usage
      bus.hid_keycode = 8'h05;
      push_level(7, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b1);
      run(7, "unmapped");

      // arrow key
      bus.hid_keycode = 8'h50;
`ifdef KEY_ARROW_EN
      push_level(7, 6'b000000, 1'b0, 6'b100000, 1'b1, 1'b1);
`else
      push_level(7, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b1);
`endif
      run(7, "arrow");
      bus.hid_keycode = 8'h00;
      push_level(7, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0);
      run(7, "arrow_release");

      // zoom-in held 60 frames, then released
      bus.hid_keycode = 8'h2E;
      push_zoom(60, 1'b0);
      run(60, "zin_hold");
      bus.hid_keycode = 8'h00;
      push_level(8, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0);
      run(8, "zin_release");

      // zoom-in into DELAY, then switch to zoom-out
      bus.hid_keycode = 8'h2E;
      push_zoom(20, 1'b0);
      run(20, "zswitch_in");
      bus.hid_keycode = 8'h2D;
      push_zoom(20, 1'b1);
      run(20, "zswitch_out");
      bus.hid_keycode = 8'h00;
      push_level(8, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0);
      run(8, "zswitch_release");

      // reset mid-REPEAT while a pulse is high
      bus.hid_keycode = 8'h2E;
      push_zoom(41, 1'b0);
      run(41, "zrst_hold");
      Reset_n         = 1'b0;
      bus.hid_keycode = 8'h00;
      #1;
      check_all_zero("async_reset");
      repeat (2) @(negedge frame_clk);
      Reset_n = 1'b1;
      push_level(12, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b1);
      run(12, "post_reset");
      bus.hid_keycode = 8'h2E;
      push_zoom(8, 1'b0);
      run(8, "repress");
      bus.hid_keycode = 8'h00;
      push_level(8, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0);
      run(8, "repress_release");

      check("sb_drained", 8'(exp_q.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
